// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, ALU command, branch type and field constants
package mips_pkg;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int DEST_HI = 25;
  localparam int DEST_LO = 21;
  localparam int SRC1_HI = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // SLA and SLL share one shifter command
  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLA = 4'b1000;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } branch_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_id_stage_if.sv
// rtl/mips_id_stage_if.sv - write-back bus from the WB stage into the ID register file
interface mips_id_stage_if;
  logic [31:0] WB_Data;
  logic [4:0]  WB_Dest;
  logic        WB_Write_Enable;

  modport master (output WB_Data, output WB_Dest, output WB_Write_Enable);
  modport slave  (input  WB_Data, input  WB_Dest, input  WB_Write_Enable);
endinterface

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 register file, two read ports with write-through, R0 hardwired
module mips_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_valid;

  assign wr_valid = we_i && (waddr_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_valid) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through lets a value leaving WB be consumed by ID in the same cycle
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (wr_valid && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (wr_valid && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = 32'd0;
    if (raddr2_i == 5'd0) rdata2_o = 32'd0;
  end

endmodule

// File: rtl/mips_id_stage.sv
// rtl/mips_id_stage.sv - MIPS instruction decode: operand read, control decode, early branch condition
module mips_id_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Instruction,
  mips_id_stage_if.slave    wb,
  output logic [31:0]       Val1,
  output logic [31:0]       Val2,
  output logic [31:0]       Reg2,
  output logic [4:0]        Dest,
  output logic [1:0]        Branch_Type,
  output logic              Br_Taken,
  output logic [3:0]        EXE_CMD,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              WB_EN
);

  logic [5:0]  opcode;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  raddr2;
  logic [31:0] imm_ext;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  logic [3:0]  cmd;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        use_imm;
  logic        rd2_is_dest;
  branch_e     br_type;
  logic        br_cond;

  assign opcode  = Instruction[OPC_HI:OPC_LO];
  assign Dest    = Instruction[DEST_HI:DEST_LO];
  assign src1    = Instruction[SRC1_HI:SRC1_LO];
  assign src2    = Instruction[SRC2_HI:SRC2_LO];
  assign imm_ext = sign_ext16(Instruction[IMM_HI:IMM_LO]);

  always_comb begin
    cmd         = CMD_ADD;
    wb_en       = 1'b0;
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    use_imm     = 1'b0;
    rd2_is_dest = 1'b0;
    br_type     = BR_NONE;
    case (opcode)
      OP_ADD:  begin cmd = CMD_ADD; wb_en = 1'b1; end
      OP_SUB:  begin cmd = CMD_SUB; wb_en = 1'b1; end
      OP_AND:  begin cmd = CMD_AND; wb_en = 1'b1; end
      OP_OR:   begin cmd = CMD_OR;  wb_en = 1'b1; end
      OP_NOR:  begin cmd = CMD_NOR; wb_en = 1'b1; end
      OP_XOR:  begin cmd = CMD_XOR; wb_en = 1'b1; end
      OP_SLA:  begin cmd = CMD_SLA; wb_en = 1'b1; end
      OP_SLL:  begin cmd = CMD_SLL; wb_en = 1'b1; end
      OP_SRA:  begin cmd = CMD_SRA; wb_en = 1'b1; end
      OP_SRL:  begin cmd = CMD_SRL; wb_en = 1'b1; end
      OP_ADDI: begin cmd = CMD_ADD; wb_en = 1'b1; use_imm = 1'b1; end
      OP_SUBI: begin cmd = CMD_SUB; wb_en = 1'b1; use_imm = 1'b1; end
      OP_LD:   begin wb_en = 1'b1; mem_r_en = 1'b1; use_imm = 1'b1; end
      OP_ST:   begin mem_w_en = 1'b1; use_imm = 1'b1; rd2_is_dest = 1'b1; end
      OP_BEZ:  begin br_type = BR_BEZ; use_imm = 1'b1; end
      OP_BNE:  begin br_type = BR_BNE; use_imm = 1'b1; rd2_is_dest = 1'b1; end
      OP_JMP:  begin br_type = BR_JMP; use_imm = 1'b1; end
      default: ;
    endcase
  end

  // ST needs the store data and BNE the compare operand, both named by dest
  assign raddr2 = rd2_is_dest ? Dest : src2;

  mips_register_file u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (src1),
    .raddr2_i (raddr2),
    .waddr_i  (wb.WB_Dest),
    .wdata_i  (wb.WB_Data),
    .we_i     (wb.WB_Write_Enable),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign Val1 = rdata1;
  assign Reg2 = rdata2;
  assign Val2 = use_imm ? imm_ext : rdata2;

  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      BR_BEZ:  br_cond = (rdata1 == 32'd0);
      BR_BNE:  br_cond = (rdata1 != rdata2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  // Control is squashed while reset is held so nothing downstream acts on a stale instruction
  assign Branch_Type = rst ? br_type  : BR_NONE;
  assign Br_Taken    = rst & br_cond;
  assign EXE_CMD     = rst ? cmd      : 4'b0000;
  assign MEM_R_EN    = rst & mem_r_en;
  assign MEM_W_EN    = rst & mem_w_en;
  assign WB_EN       = rst & wb_en;

endmodule

// File: tb/tb_mips_id_stage.sv
// tb/tb_mips_id_stage.sv - self-checking bench for mips_id_stage with a behavioural reference model
module tb_mips_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] Instruction;
  logic [31:0] Val1, Val2, Reg2;
  logic [4:0]  Dest;
  logic [1:0]  Branch_Type;
  logic        Br_Taken, MEM_R_EN, MEM_W_EN, WB_EN;
  logic [3:0]  EXE_CMD;

  mips_id_stage_if wb_if ();

  mips_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .Instruction (Instruction),
    .wb          (wb_if.slave),
    .Val1        (Val1),
    .Val2        (Val2),
    .Reg2        (Reg2),
    .Dest        (Dest),
    .Branch_Type (Branch_Type),
    .Br_Taken    (Br_Taken),
    .EXE_CMD     (EXE_CMD),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .WB_EN       (WB_EN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rf [32];

  typedef struct {
    logic [31:0] v1, v2, r2;
    logic [4:0]  dest;
    logic [1:0]  bt;
    logic        tk;
    logic [3:0]  cmd;
    logic        mr, mw, wb;
  } exp_t;

  function automatic logic [31:0] ins_r(input int op, input int d, input int s1, input int s2);
    return {6'(op), 5'(d), 5'(s1), 5'(s2), 11'd0};
  endfunction

  function automatic logic [31:0] ins_i(input int op, input int d, input int s1, input int imm);
    return {6'(op), 5'(d), 5'(s1), 16'(imm)};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_if.WB_Write_Enable && wb_if.WB_Dest == a) return wb_if.WB_Data;
    return model_rf[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic rst_n);
    exp_t e;
    int   op;
    logic imm_op;
    logic [4:0] a2;
    op = int'(ins[31:26]);
    e.cmd = 4'd0; e.mr = 0; e.mw = 0; e.wb = 0; e.bt = 2'd0; imm_op = 0;
    case (op)
      1:  begin e.cmd = 4'd0;  e.wb = 1; end
      3:  begin e.cmd = 4'd2;  e.wb = 1; end
      5:  begin e.cmd = 4'd4;  e.wb = 1; end
      6:  begin e.cmd = 4'd5;  e.wb = 1; end
      7:  begin e.cmd = 4'd6;  e.wb = 1; end
      8:  begin e.cmd = 4'd7;  e.wb = 1; end
      9:  begin e.cmd = 4'd8;  e.wb = 1; end
      10: begin e.cmd = 4'd8;  e.wb = 1; end
      11: begin e.cmd = 4'd9;  e.wb = 1; end
      12: begin e.cmd = 4'd10; e.wb = 1; end
      32: begin e.cmd = 4'd0;  e.wb = 1; imm_op = 1; end
      33: begin e.cmd = 4'd2;  e.wb = 1; imm_op = 1; end
      36: begin e.wb = 1; e.mr = 1; imm_op = 1; end
      37: begin e.mw = 1; imm_op = 1; end
      40: begin e.bt = 2'd1; imm_op = 1; end
      41: begin e.bt = 2'd2; imm_op = 1; end
      42: begin e.bt = 2'd3; imm_op = 1; end
      default: ;
    endcase
    e.dest = ins[25:21];
    a2   = (op == 37 || op == 41) ? ins[25:21] : ins[15:11];
    e.v1 = model_read(ins[20:16]);
    e.r2 = model_read(a2);
    e.v2 = imm_op ? {{16{ins[15]}}, ins[15:0]} : e.r2;
    e.tk = (op == 40) ? (e.v1 == 32'd0) : (op == 41) ? (e.v1 != e.r2) : (op == 42);
    if (!rst_n) begin
      e.cmd = 4'd0; e.mr = 0; e.mw = 0; e.wb = 0; e.bt = 2'd0; e.tk = 0;
    end
    return e;
  endfunction

  task automatic do_write(input int dest, input logic [31:0] data);
    @(negedge clk);
    wb_if.WB_Write_Enable = 1'b1;
    wb_if.WB_Dest = 5'(dest);
    wb_if.WB_Data = data;
    @(posedge clk);
    if (rst && dest != 0) model_rf[dest] = data;
    #1 wb_if.WB_Write_Enable = 1'b0;
  endtask

  task automatic apply(input logic [31:0] ins);
    @(negedge clk);
    Instruction = ins;
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wb_if.WB_Write_Enable = 1'b1;
    wb_if.WB_Dest = 5'd1;
    wb_if.WB_Data = 32'h77;
    Instruction = 32'h04221800;
    @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if ({WB_EN, MEM_R_EN, MEM_W_EN, Br_Taken, Branch_Type, EXE_CMD} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl_forced got=%b want=0", {WB_EN, MEM_R_EN, MEM_W_EN, Br_Taken, Branch_Type, EXE_CMD});
    end
    checks++;
    if (Dest !== 5'd1) begin errors++; $display("FAIL reset_dest got=%0d want=1", Dest); end
    @(posedge clk);
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    #1 wb_if.WB_Write_Enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (Val1 !== 32'd0 || Val2 !== 32'd0) begin errors++; $display("FAIL reset_read got=%h/%h want=0/0", Val1, Val2); end
    checks++;
    if (WB_EN !== 1'b1 || EXE_CMD !== 4'd0 || Dest !== 5'd1) begin
      errors++; $display("FAIL reset_add_decode got wb=%b cmd=%h dest=%0d want 1/0/1", WB_EN, EXE_CMD, Dest);
    end
    apply(ins_r(1, 0, 1, 0));
    checks++;
    if (Val1 !== 32'd0) begin errors++; $display("FAIL reset_write_discarded got=%h want=0", Val1); end
  endtask

  task automatic test_write_read;
    do_write(2, 32'd5);
    do_write(3, 32'd7);
    apply(32'h04221800);
    checks++;
    if (Val1 !== 32'd5 || Val2 !== 32'd7) begin errors++; $display("FAIL write_read got=%0d/%0d want=5/7", Val1, Val2); end
    do_write(0, 32'd9);
    apply(ins_r(1, 1, 0, 0));
    checks++;
    if (Val1 !== 32'd0 || Val2 !== 32'd0) begin errors++; $display("FAIL r0_hardwired got=%h/%h want=0/0", Val1, Val2); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    Instruction = 32'h04221800;
    wb_if.WB_Write_Enable = 1'b1;
    wb_if.WB_Dest = 5'd2;
    wb_if.WB_Data = 32'hAA;
    #2;
    checks++;
    if (Val1 !== 32'hAA) begin errors++; $display("FAIL bypass got=%h want=000000aa", Val1); end
    @(posedge clk);
    model_rf[2] = 32'hAA;
    #1 wb_if.WB_Write_Enable = 1'b0;
    apply(32'h04221800);
    checks++;
    if (Val1 !== 32'hAA) begin errors++; $display("FAIL bypass_stored got=%h want=000000aa", Val1); end
  endtask

  task automatic test_imm_mem;
    apply(ins_i(32, 1, 2, -4));
    checks++;
    if (Val2 !== 32'hFFFFFFFC || EXE_CMD !== 4'd0 || WB_EN !== 1'b1) begin
      errors++; $display("FAIL addi got v2=%h cmd=%h wb=%b want fffffffc/0/1", Val2, EXE_CMD, WB_EN);
    end
    do_write(4, 32'h55);
    apply(ins_i(37, 4, 2, 8));
    checks++;
    if (Reg2 !== 32'h55 || MEM_W_EN !== 1'b1 || WB_EN !== 1'b0 || Val2 !== 32'd8) begin
      errors++; $display("FAIL st got r2=%h mw=%b wb=%b v2=%h want 55/1/0/8", Reg2, MEM_W_EN, WB_EN, Val2);
    end
    apply(ins_i(36, 5, 2, 8));
    checks++;
    if (MEM_R_EN !== 1'b1 || WB_EN !== 1'b1 || MEM_W_EN !== 1'b0) begin
      errors++; $display("FAIL ld got mr=%b wb=%b mw=%b want 1/1/0", MEM_R_EN, WB_EN, MEM_W_EN);
    end
  endtask

  task automatic test_branches;
    apply(ins_i(40, 0, 6, 16));
    checks++;
    if (Br_Taken !== 1'b1 || Branch_Type !== 2'b01) begin
      errors++; $display("FAIL bez_taken got tk=%b bt=%b want 1/01", Br_Taken, Branch_Type);
    end
    apply(ins_i(40, 0, 2, 16));
    checks++;
    if (Br_Taken !== 1'b0) begin errors++; $display("FAIL bez_not_taken got=%b want=0", Br_Taken); end
    apply(ins_i(41, 3, 3, 16));
    checks++;
    if (Br_Taken !== 1'b0 || Branch_Type !== 2'b10) begin
      errors++; $display("FAIL bne_equal got tk=%b bt=%b want 0/10", Br_Taken, Branch_Type);
    end
    apply(ins_i(41, 3, 2, 16));
    checks++;
    if (Br_Taken !== 1'b1 || Reg2 !== 32'd7) begin
      errors++; $display("FAIL bne_differ got tk=%b r2=%h want 1/7", Br_Taken, Reg2);
    end
    apply(ins_i(42, 0, 0, -2));
    checks++;
    if (Br_Taken !== 1'b1 || Branch_Type !== 2'b11 || Val2 !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL jmp got tk=%b bt=%b v2=%h want 1/11/fffffffe", Br_Taken, Branch_Type, Val2);
    end
  endtask

  task automatic test_nop;
    apply({6'd63, 26'h3FFFFFF});
    checks++;
    if ({WB_EN, MEM_R_EN, MEM_W_EN, Br_Taken, Branch_Type, EXE_CMD} !== 10'd0) begin
      errors++; $display("FAIL illegal_opcode got=%b want=0", {WB_EN, MEM_R_EN, MEM_W_EN, Br_Taken, Branch_Type, EXE_CMD});
    end
  endtask

  task automatic test_random;
    int   legal [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
    int   op;
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : legal[$urandom_range(0, 17)];
      Instruction = {6'(op), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 11'($urandom)};
      wb_if.WB_Write_Enable = 1'($urandom_range(0, 1));
      wb_if.WB_Dest = 5'($urandom_range(0, 7));
      wb_if.WB_Data = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(0, 3));
      rst = ($urandom_range(0, 31) != 0);
      #2;
      e = model(Instruction, rst);
      checks++;
      if (Val1 !== e.v1) begin errors++; $display("FAIL rand_val1 ins=%h got=%h want=%h", Instruction, Val1, e.v1); end
      checks++;
      if (Val2 !== e.v2) begin errors++; $display("FAIL rand_val2 ins=%h got=%h want=%h", Instruction, Val2, e.v2); end
      checks++;
      if (Reg2 !== e.r2) begin errors++; $display("FAIL rand_reg2 ins=%h got=%h want=%h", Instruction, Reg2, e.r2); end
      checks++;
      if ({Dest, Branch_Type, Br_Taken, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN} !==
          {e.dest, e.bt, e.tk, e.cmd, e.mr, e.mw, e.wb}) begin
        errors++;
        $display("FAIL rand_ctrl ins=%h rst=%b got=%b want=%b", Instruction, rst,
                 {Dest, Branch_Type, Br_Taken, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN},
                 {e.dest, e.bt, e.tk, e.cmd, e.mr, e.mw, e.wb});
      end
      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      end else if (wb_if.WB_Write_Enable && wb_if.WB_Dest != 5'd0) begin
        model_rf[wb_if.WB_Dest] = wb_if.WB_Data;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    wb_if.WB_Write_Enable = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    Instruction = 32'd0;
    wb_if.WB_Write_Enable = 1'b0;
    wb_if.WB_Dest = 5'd0;
    wb_if.WB_Data = 32'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    test_reset;
    test_write_read;
    test_bypass;
    test_imm_mem;
    test_branches;
    test_nop;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
